// File: rtl/openhw_pack_output_pkg.sv
// Shared FPU format constants and configuration record for the result packer.
// Holds per-format field widths and biases plus format-support helpers.
package openhw_pack_output_pkg;

  typedef struct packed {
    int   FLEN;
    int   NE;
    int   NF;
    int   FMTBITS;
    logic F_SUPPORTED;
    logic D_SUPPORTED;
    logic Q_SUPPORTED;
    logic ZFH_SUPPORTED;
  } cvw_t;

  // RV64 with F and D: the configuration the packer is normally built for.
  localparam cvw_t CVW_RV64 = '{
    FLEN: 64, NE: 11, NF: 52, FMTBITS: 2,
    F_SUPPORTED: 1'b1, D_SUPPORTED: 1'b1, Q_SUPPORTED: 1'b0, ZFH_SUPPORTED: 1'b0
  };

  localparam int NE_H = 5;
  localparam int NF_H = 10;
  localparam int BIAS_H = 15;
  localparam int NE_S = 8;
  localparam int NF_S = 23;
  localparam int BIAS_S = 127;
  localparam int NE_D = 11;
  localparam int NF_D = 52;
  localparam int BIAS_D = 1023;
  localparam int NE_Q = 15;
  localparam int NF_Q = 112;
  localparam int BIAS_Q = 16383;

  // Widest IEEE word any configuration can produce.
  localparam int MAX_W = 1 + NE_Q + NF_Q;

  typedef enum logic [1:0] {
    FMT_S = 2'b00,
    FMT_D = 2'b01,
    FMT_H = 2'b10,
    FMT_Q = 2'b11
  } fmt_e;

  function automatic logic fmt_supported(cvw_t p, fmt_e f);
    case (f)
      FMT_H:   return p.ZFH_SUPPORTED;
      FMT_S:   return p.F_SUPPORTED;
      FMT_D:   return p.D_SUPPORTED;
      default: return p.Q_SUPPORTED;
    endcase
  endfunction

  function automatic fmt_e largest_fmt(cvw_t p);
    if (p.Q_SUPPORTED) return FMT_Q;
    if (p.D_SUPPORTED) return FMT_D;
    if (p.F_SUPPORTED) return FMT_S;
    return FMT_H;
  endfunction

  function automatic logic [NE_Q-1:0] fmt_bias(fmt_e f);
    case (f)
      FMT_H:   return NE_Q'(BIAS_H);
      FMT_S:   return NE_Q'(BIAS_S);
      FMT_D:   return NE_Q'(BIAS_D);
      default: return NE_Q'(BIAS_Q);
    endcase
  endfunction

endpackage

// File: rtl/openhw_packfmt.sv
// Combinational re-encoder: internal (sign, wide exponent, MSB-aligned fraction,
// class flags) to a NaN-boxed IEEE-754 word of the selected format.
module openhw_packfmt
  import openhw_pack_output_pkg::*;
#(
  parameter cvw_t P = CVW_RV64
) (
  input  logic                 Sgn,
  input  logic [P.NE-1:0]      Exp,
  input  logic [P.NF-1:0]      Frac,
  input  logic [P.FMTBITS-1:0] Fmt,
  input  logic                 NaN,
  input  logic                 Inf,
  input  logic                 Zero,
  input  logic                 Subnorm,
  output logic [P.FLEN-1:0]    Result
);

  localparam logic [NE_Q-1:0] BIASL = NE_Q'((1 << (P.NE - 1)) - 1);

  fmt_e            fmt_req;
  fmt_e            fmt_eff;
  logic [NF_Q-1:0] frac_q;
  logic            s_field;
  logic [NE_Q-1:0] e_field;
  logic [NF_Q-1:0] f_field;
  logic [MAX_W-1:0] body;

  // Narrow configurations encode only S/D in one bit; zero-extension maps them directly.
  always_comb begin
    fmt_req = fmt_e'(2'(Fmt));
    fmt_eff = fmt_supported(P, fmt_req) ? fmt_req : largest_fmt(P);
  end

  // Left-justify the fraction in a quad-width field so each format takes its top nf bits.
  always_comb frac_q = NF_Q'({Frac, {NF_Q{1'b0}}} >> P.NF);

  // NOTE: every output of this block gets a default before the priority chain, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    s_field = Sgn;
    e_field = NE_Q'(Exp) - BIASL + fmt_bias(fmt_eff);
    f_field = frac_q;
    if (NaN) begin
      s_field = 1'b0;
      e_field = '1;
      f_field = {1'b1, {(NF_Q-1){1'b0}}};
    end else if (Inf) begin
      e_field = '1;
      f_field = '0;
    end else if (Zero) begin
      e_field = '0;
      f_field = '0;
    end else if (Subnorm) begin
      e_field = '0;
    end
  end

  // Bits above the packed format stay all ones, which is the NaN box.
  always_comb begin
    body = '1;
    unique case (fmt_eff)
      FMT_H: body[NE_H+NF_H:0] = {s_field, e_field[NE_H-1:0], f_field[NF_Q-1 -: NF_H]};
      FMT_S: body[NE_S+NF_S:0] = {s_field, e_field[NE_S-1:0], f_field[NF_Q-1 -: NF_S]};
      FMT_D: body[NE_D+NF_D:0] = {s_field, e_field[NE_D-1:0], f_field[NF_Q-1 -: NF_D]};
      FMT_Q: body[NE_Q+NF_Q:0] = {s_field, e_field, f_field};
    endcase
  end

  assign Result = P.FLEN'(body);

endmodule

// File: rtl/openhw_pack_output.sv
// FPU result packer with a 2-entry output buffer between the rounder and writeback.
// InReady comes only from registered occupancy, so writeback stalls never reach the rounder combinationally.
module openhw_pack_output
  import openhw_pack_output_pkg::*;
#(
  parameter cvw_t P     = CVW_RV64,
  parameter int   DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Flush,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic                 Sgn,
  input  logic [P.NE-1:0]      Exp,
  input  logic [P.NF-1:0]      Frac,
  input  logic [P.FMTBITS-1:0] Fmt,
  input  logic                 NaN,
  input  logic                 Inf,
  input  logic                 Zero,
  input  logic                 Subnorm,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [P.FLEN-1:0]    OutResult
);

  typedef logic [P.FLEN-1:0] entry_t;

  entry_t     packed_word;
  entry_t     slots [DEPTH];
  logic [1:0] count;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       push;
  logic       pop;

  openhw_packfmt #(.P(P)) u_packfmt (
    .Sgn     (Sgn),
    .Exp     (Exp),
    .Frac    (Frac),
    .Fmt     (Fmt),
    .NaN     (NaN),
    .Inf     (Inf),
    .Zero    (Zero),
    .Subnorm (Subnorm),
    .Result  (packed_word)
  );

  assign InReady  = (count < 2'(DEPTH));
  assign OutValid = (count != 2'd0);
  assign push     = InValid & InReady & ~Flush;
  assign pop      = OutValid & OutReady;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || Flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is not reset; the head is masked while empty so stale words never reach the output.
  always_ff @(posedge clk) begin
    if (push) slots[wr_ptr] <= packed_word;
  end

  assign OutResult = OutValid ? slots[rd_ptr] : '0;

endmodule

// File: tb/tb_openhw_pack_output.sv
// Self-checking bench for openhw_pack_output: directed vector table, handshake
// corner sequences, and randomized traffic against a queue-based reference model.
module tb_openhw_pack_output;
  import openhw_pack_output_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Flush = 1'b0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic        Sgn = 1'b0;
  logic [10:0] Exp = '0;
  logic [51:0] Frac = '0;
  logic [1:0]  Fmt = '0;
  logic        NaN = 1'b0;
  logic        Inf = 1'b0;
  logic        Zero = 1'b0;
  logic        Subnorm = 1'b0;
  logic        OutValid;
  logic        OutReady = 1'b0;
  logic [63:0] OutResult;

  openhw_pack_output #(.P(CVW_RV64), .DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .Flush     (Flush),
    .InValid   (InValid),
    .InReady   (InReady),
    .Sgn       (Sgn),
    .Exp       (Exp),
    .Frac      (Frac),
    .Fmt       (Fmt),
    .NaN       (NaN),
    .Inf       (Inf),
    .Zero      (Zero),
    .Subnorm   (Subnorm),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .OutResult (OutResult)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sgn;
    logic [10:0] exp;
    logic [51:0] frac;
    logic [1:0]  fmt;
    logic        nan;
    logic        inf;
    logic        zero;
    logic        sub;
  } in_t;

  typedef struct {
    string       name;
    in_t         in;
    logic [63:0] out;
  } vec_t;

  typedef struct {
    string       name;
    logic [63:0] val;
  } exp_t;

  int     checks = 0;
  int     failures = 0;
  exp_t   exp_q[$];
  vec_t   tv[$];
  logic   cleared = 1'b0;
  in_t    idle = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, req);
    end
  endtask

  function automatic in_t mk(logic sgn, logic [10:0] exp, logic [51:0] frac, logic [1:0] fmt,
                             logic nan, logic inf, logic zero, logic sub);
    in_t v;
    v.sgn = sgn; v.exp = exp; v.frac = frac; v.fmt = fmt;
    v.nan = nan; v.inf = inf; v.zero = zero; v.sub = sub;
    return v;
  endfunction

  // Reference encoding from the format field table; RV64 has only S and D, so other codes pack as D.
  function automatic logic [63:0] ref_pack(in_t v);
    int ne, nf, bias;
    logic [63:0] s, e, f, w;
    if (v.fmt == 2'b00) begin ne = 8; nf = 23; bias = 127; end
    else begin ne = 11; nf = 52; bias = 1023; end
    s = 64'(v.sgn);
    f = 64'(v.frac) >> (52 - nf);
    if (v.nan) begin
      s = 64'd0; e = (64'd1 << ne) - 64'd1; f = 64'd1 << (nf - 1);
    end else if (v.inf) begin
      e = (64'd1 << ne) - 64'd1; f = 64'd0;
    end else if (v.zero) begin
      e = 64'd0; f = 64'd0;
    end else if (v.sub) begin
      e = 64'd0;
    end else begin
      e = (64'(v.exp) - 64'd1023 + 64'(bias)) & ((64'd1 << ne) - 64'd1);
    end
    w = (s << (ne + nf)) | (e << nf) | f;
    if (ne + nf + 1 < 64) w = w | (~64'd0 << (ne + nf + 1));
    return w;
  endfunction

  function automatic in_t rand_in();
    in_t v;
    int  et;
    v.fmt  = 2'($urandom_range(0, 3));
    v.sgn  = 1'($urandom);
    v.frac = 52'({$urandom, $urandom});
    if (v.fmt == 2'b00) begin
      et = int'($urandom_range(1, 254));
      v.exp = 11'(et - 127 + 1023);
    end else begin
      et = int'($urandom_range(1, 2046));
      v.exp = 11'(et);
    end
    v.nan  = ($urandom_range(0, 11) == 0);
    v.inf  = ($urandom_range(0, 11) == 0);
    v.zero = ($urandom_range(0, 9) == 0);
    v.sub  = ($urandom_range(0, 7) == 0);
    return v;
  endfunction

  // One clock: drive at negedge, sample just after, compare with the model, update the model.
  task automatic step(input logic vld, input in_t v, input logic [63:0] val, input string tag,
                      input logic rdy, input logic flush = 1'b0, input logic rst = 1'b0);
    int n;
    @(negedge clk);
    reset = rst; Flush = flush; InValid = vld; OutReady = rdy;
    Sgn = v.sgn; Exp = v.exp; Frac = v.frac; Fmt = v.fmt;
    NaN = v.nan; Inf = v.inf; Zero = v.zero; Subnorm = v.sub;
    #1;
    if (rst || flush) begin
      exp_q.delete();
      cleared = 1'b1;
      return;
    end
    n = exp_q.size();
    check({tag, " in_ready"}, 64'(InReady), 64'(n < 2));
    check({tag, " out_valid"}, 64'(OutValid), 64'(n > 0));
    if (cleared) begin
      check({tag, " out_result_cleared"}, OutResult, 64'd0);
      cleared = 1'b0;
    end
    if (n > 0) begin
      check({exp_q[0].name, " out_result"}, OutResult, exp_q[0].val);
      if (rdy) void'(exp_q.pop_front());
    end
    if (vld && n < 2) exp_q.push_back('{tag, val});
  endtask

  task automatic idle_step(input string tag, input logic rdy);
    step(1'b0, idle, 64'd0, tag, rdy);
  endtask

  initial begin
    in_t a, b, c, d;

    tv.push_back('{"s_one",       mk(0, 11'h3FF, 52'h0, 2'b00, 0, 0, 0, 0), 64'hFFFFFFFF_3F800000});
    tv.push_back('{"d_m2p5",      mk(1, 11'h400, 52'h4_0000_0000_0000, 2'b01, 0, 0, 0, 0), 64'hC004_0000_0000_0000});
    tv.push_back('{"d_minf",      mk(1, 11'h123, 52'h5, 2'b01, 0, 1, 0, 0), 64'hFFF0_0000_0000_0000});
    tv.push_back('{"s_nan_inf",   mk(1, 11'h3FF, 52'h1, 2'b00, 1, 1, 0, 0), 64'hFFFFFFFF_7FC00000});
    tv.push_back('{"s_sub",       mk(0, 11'h000, 52'h8_0000_0000_0000, 2'b00, 0, 0, 0, 1), 64'hFFFFFFFF_00400000});
    tv.push_back('{"s_mzero",     mk(1, 11'h3FF, 52'h0, 2'b00, 0, 0, 1, 0), 64'hFFFFFFFF_80000000});
    tv.push_back('{"d_nan",       mk(1, 11'h7FF, 52'hF, 2'b01, 1, 0, 0, 1), 64'h7FF8_0000_0000_0000});
    tv.push_back('{"q_as_d_one",  mk(0, 11'h3FF, 52'h0, 2'b11, 0, 0, 0, 0), 64'h3FF0_0000_0000_0000});
    tv.push_back('{"h_as_d",      mk(1, 11'h3FF, 52'h8_0000_0000_0000, 2'b10, 0, 0, 0, 0), 64'hBFF8_0000_0000_0000});
    tv.push_back('{"s_zero_sub",  mk(0, 11'h000, 52'hF_0000_0000_0000, 2'b00, 0, 0, 1, 1), 64'hFFFFFFFF_00000000});
    tv.push_back('{"s_max",       mk(0, 11'h47E, 52'hF_FFFF_FFFF_FFFF, 2'b00, 0, 0, 0, 0), 64'hFFFFFFFF_7F7FFFFF});
    tv.push_back('{"s_min_norm",  mk(0, 11'h381, 52'h0, 2'b00, 0, 0, 0, 0), 64'hFFFFFFFF_00800000});
    tv.push_back('{"d_inf_zero",  mk(0, 11'h000, 52'h0, 2'b01, 0, 1, 1, 0), 64'h7FF0_0000_0000_0000});

    // Reset, then verify the cleared state.
    step(1'b0, idle, 64'd0, "rst", 1'b0, 1'b0, 1'b1);
    step(1'b0, idle, 64'd0, "rst", 1'b0, 1'b0, 1'b1);
    idle_step("post_reset", 1'b1);

    // Directed encodings streamed back to back; each appears one cycle after accept.
    foreach (tv[i]) step(1'b1, tv[i].in, tv[i].out, tv[i].name, 1'b1);
    idle_step("tbl_drain", 1'b1);
    idle_step("tbl_idle", 1'b1);

    // Backpressure: A and B fill the buffer, C is held until a pop frees a slot.
    a = rand_in(); b = rand_in(); c = rand_in();
    step(1'b1, a, ref_pack(a), "bp_a", 1'b0);
    step(1'b1, b, ref_pack(b), "bp_b", 1'b0);
    step(1'b1, c, ref_pack(c), "bp_c_held", 1'b0);
    step(1'b1, c, ref_pack(c), "bp_c_held", 1'b0);
    step(1'b1, c, ref_pack(c), "bp_c_pop_a", 1'b1);
    step(1'b1, c, ref_pack(c), "bp_c", 1'b1);
    idle_step("bp_drain", 1'b1);
    idle_step("bp_idle", 1'b1);

    // Simultaneous push and pop with one entry resident.
    a = rand_in();
    step(1'b1, a, ref_pack(a), "sim_fill", 1'b1);
    for (int i = 0; i < 10; i++) begin
      b = rand_in();
      step(1'b1, b, ref_pack(b), "sim", 1'b1);
    end
    idle_step("sim_drain", 1'b1);
    idle_step("sim_idle", 1'b1);

    // Flush with two entries; the input offered during Flush must be dropped.
    a = rand_in(); b = rand_in(); d = rand_in();
    step(1'b1, a, ref_pack(a), "fl_a", 1'b0);
    step(1'b1, b, ref_pack(b), "fl_b", 1'b0);
    step(1'b1, d, ref_pack(d), "fl", 1'b1, 1'b1);
    idle_step("post_flush", 1'b1);
    idle_step("post_flush2", 1'b1);

    // Reset mid-stream.
    a = rand_in(); b = rand_in(); d = rand_in();
    step(1'b1, a, ref_pack(a), "rs_a", 1'b0);
    step(1'b1, b, ref_pack(b), "rs_b", 1'b1);
    step(1'b1, d, ref_pack(d), "rs", 1'b1, 1'b0, 1'b1);
    idle_step("post_reset_mid", 1'b1);
    idle_step("post_reset_mid2", 1'b1);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      in_t v;
      v = rand_in();
      step(($urandom_range(0, 3) != 0), v, ref_pack(v), "rnd",
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 59) == 0));
    end
    for (int i = 0; i < 4; i++) idle_step("rnd_drain", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/openhw_pack_output.md
Name: openhw_pack_output

Overview:
Inverse of the operand unpacker. Takes a result in the FPU's internal largest-precision form: sign, exponent biased for the largest format, MSB-aligned fraction, and class flags. It re-encodes that result into the IEEE-754 bit pattern of the selected format and NaN-boxes it to FLEN. Sits between the FPU post-processing/rounding stage and FPU writeback. It has a valid/ready handshake and a 2-entry output buffer so writeback stalls do not stall the rounder.

Parameters:
- P, no default (cvw_t, required): configuration record. Uses P.FLEN, P.NE, P.NF, P.FMTBITS, P.F_SUPPORTED, P.D_SUPPORTED, P.Q_SUPPORTED, P.ZFH_SUPPORTED.
- DEPTH, 2: output buffer entries. Only 2 is supported.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- Flush  in  1  discard all buffered results
- InValid  in  1  input result valid
- InReady  out  1  block can accept an input this cycle
- Sgn  in  1  result sign
- Exp  in  P.NE  exponent, biased for largest format
- Frac  in  P.NF  fraction without hidden bit, MSB-aligned, already rounded to target precision
- Fmt  in  P.FMTBITS  00 single, 01 double, 11 quad, 10 half
- NaN, Inf, Zero, Subnorm  in  1 each  result class flags
- OutValid  out  1  packed result valid
- OutReady  in  1  consumer accepts result
- OutResult  out  P.FLEN  packed, NaN-boxed result

Behaviour:
- Reset (synchronous, active-high) and Flush: buffer count=0, OutValid=0, OutResult=0 on the next edge. Reset and Flush mid-transfer drop all entries.
- InReady = (count<2). It depends only on registered state; there is no combinational path from OutReady.
- Push when InValid&InReady. Pop when OutValid&OutReady. Push and pop in the same cycle leave count unchanged. Order is FIFO.
- Latency: a result accepted at edge N appears on OutValid/OutResult after edge N, provided the buffer was empty. Otherwise it follows the older entry.
- OutResult is the head entry and is held stable while OutValid&~OutReady.
- Encoding is combinational on the inputs and the packed word is stored. Field widths per Fmt are (ne, nf, bias):
  - half: 5, 10, 15
  - single: 8, 23, 127
  - double: 11, 52, 1023
  - quad: 15, 112, 16383
- BIASL = 2^(P.NE-1)-1.
- Class priority is NaN > Inf > Zero > Subnorm > normal:
  - NaN: canonical quiet NaN. sign 0, exp all ones, frac MSB 1, rest 0. The input sign is ignored.
  - Inf: Sgn, exp all ones, frac 0.
  - Zero: Sgn, exp 0, frac 0.
  - Subnorm: Sgn, exp 0, frac = Frac[P.NF-1 -: nf].
  - normal: Sgn, exp = low ne bits of (Exp - BIASL + bias), frac = Frac[P.NF-1 -: nf]. Exp is in range by contract; there is no saturation.
- NaN-boxing: bits above 1+ne+nf are all ones. When Fmt is the largest format there is no padding.
- Fmt encoding an unsupported precision packs as the largest supported format.
- Multiple class flags set at once are resolved by the priority above. This is not an error.
- Push while Flush=1 is dropped.

Decomposition:
- cvw package: add format width/bias constants (NE/NF/BIAS for H, S, D, Q) beside the existing ones, plus a packed-entry typedef of width P.FLEN.
- One sub-module: openhw_packfmt. It holds the combinational class-priority encoding and NaN-boxing, and is reusable by the convert unit.
- The top level holds the 2-entry buffer and handshake.

Test Plan (RV64 config, FLEN=64, NE=11, NF=52, F and D supported):
- Single 1.0: Sgn=0, Exp=0x3FF, Frac=0, Fmt=00 -> OutResult=0xFFFFFFFF_3F800000, OutValid one cycle after accept.
- Double -2.5: Sgn=1, Exp=0x400, Frac=0x4_0000_0000_0000, Fmt=01 -> 0xC004_0000_0000_0000. Double -Inf -> 0xFFF0_0000_0000_0000.
- Single NaN with Sgn=1 plus Inf=1 -> 0xFFFFFFFF_7FC00000. Single subnormal with Frac=0x8_0000_0000_0000 -> 0xFFFFFFFF_00400000. Single -0 -> 0xFFFFFFFF_80000000.
- Backpressure: OutReady=0, three back-to-back inputs A,B,C -> A and B accepted, InReady=0 while C is held. Raising OutReady pops A, InReady rises, C is accepted, output order is A,B,C. OutResult stays stable while stalled.
- Simultaneous push/pop at count=1 for 10 cycles -> count stays 1, stream is in order with no bubbles.
- Flush with 2 entries, and reset asserted mid-stream -> next cycle OutValid=0, OutResult=0, InReady=1. An input presented during Flush never appears at the output.
